// File: rtl/bd_merge_pkg.sv
// Shared types and constants for the N-input BD word merge.
// No logic of its own; the default code-table builder is elaborated at compile time.
// No flow control here.
package bd_merge_pkg;

  // Leaf code inserted by the tag/count source when a channel carries payload only
  localparam int TAG_CT_CODE = 30;

  // Upper bounds used to size the shared skid-buffer entry
  localparam int MAX_NIN   = 16;
  localparam int MAX_NCODE = 32;
  localparam int MAX_WORD  = 64;
  localparam int MAX_SRC   = 4;

  typedef enum logic {ARB, LOCK} arb_state_t;

  typedef struct packed {
    logic [MAX_WORD-1:0] word;
    logic [MAX_SRC-1:0]  src;
  } skid_entry_t;

  // Builds a table with TAG_CT_CODE in every nin slot of ncode bits, slot 0 at the LSB
  function automatic logic [MAX_NIN*MAX_NCODE-1:0] default_code_table(input int nin, input int ncode);
    logic [MAX_NIN*MAX_NCODE-1:0] t;
    t = '0;
    for (int i = 0; i < MAX_NIN; i++) begin
      for (int b = 0; b < MAX_NCODE; b++) begin
        if (i < nin && b < ncode) t[i*ncode+b] = TAG_CT_CODE[b];
      end
    end
    return t;
  endfunction

endpackage

// File: rtl/bd_word_merge_n_arb.sv
// Round-robin arbiter that holds its grant on one input until that input's last word.
// Grant is combinational from registered ptr/lock state and req; state updates on the transfer edge.
// Never stalls by itself; the caller gates the grant with buffer space.
module rr_arbiter_lock
  import bd_merge_pkg::*;
#(
  parameter int NIN = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NIN-1:0]         req,
  input  logic [NIN-1:0]         last,
  input  logic                   xfer,
  output logic [NIN-1:0]         grant,
  output logic [$clog2(NIN)-1:0] grant_idx
);

  localparam int IW = $clog2(NIN);

  arb_state_t    state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] lock_idx;
  logic [IW-1:0] cand;
  logic          hit;

  // Locked: hold the lock owner. Otherwise first requester after ptr, wrapping at NIN-1.
  always_comb begin
    grant     = '0;
    grant_idx = lock_idx;
    cand      = '0;
    hit       = 1'b0;
    if (state == LOCK) begin
      grant = NIN'(1) << lock_idx;
    end else begin
      grant_idx = '0;
      for (int k = 1; k <= NIN; k++) begin
        cand = IW'((int'(ptr) + k) % NIN);
        if (!hit && req[cand]) begin
          hit       = 1'b1;
          grant_idx = cand;
        end
      end
      if (hit) grant = NIN'(1) << grant_idx;
    end
  end

  // Every transfer moves ptr; a non-last word locks, the owner's last word unlocks
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ARB;
      ptr      <= IW'(NIN - 1);
      lock_idx <= '0;
    end else if (xfer) begin
      ptr <= grant_idx;
      if (state == ARB && !last[grant_idx]) begin
        state    <= LOCK;
        lock_idx <= grant_idx;
      end else if (state == LOCK && last[grant_idx]) begin
        state <= ARB;
      end
    end
  end

endmodule

// File: rtl/bd_word_merge_n.sv
// N-input merge with per-input code insertion, locked round-robin and a 2-entry skid buffer.
// One cycle: a word accepted at edge k is on out_d from edge k; one word per cycle sustained.
// in_a drops when both skid entries are full; in_a never depends on out_a. Counters: BD_MERGE_COUNT_EN.
module bd_word_merge_n
  import bd_merge_pkg::*;
#(
  parameter int                   NIN         = 4,
  parameter int                   NPAYLOAD    = 20,
  parameter int                   NCODE       = 6,
  parameter logic [NIN-1:0]       INSERT_CODE = '0,
  parameter logic [NIN*NCODE-1:0] CODE_TABLE  = (NIN*NCODE)'(default_code_table(NIN, NCODE)),
  parameter int                   NCNT        = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NIN-1:0]                      in_v,
  input  logic [NIN*(NPAYLOAD+NCODE)-1:0]     in_d,
  input  logic [NIN-1:0]                      in_last,
  output logic [NIN-1:0]                      in_a,
  output logic                                out_v,
  output logic [NPAYLOAD+NCODE-1:0]           out_d,
  output logic [$clog2(NIN)-1:0]              out_src,
  input  logic                                out_a
`ifdef BD_MERGE_COUNT_EN
  ,
  input  logic                                cnt_clear,
  output logic [NIN*NCNT-1:0]                 cnt
`endif
);

  localparam int W  = NPAYLOAD + NCODE;
  localparam int SW = $clog2(NIN);

  logic [NIN-1:0] grant;
  logic [SW-1:0]  grant_idx;
  logic           xfer;
  logic           pop;
  logic [1:0]     occ;
  logic [1:0]     occ_n;
  logic [W-1:0]   new_word;
  skid_entry_t    new_entry;
  skid_entry_t    skid_q [2];
  logic           unused_head;

  rr_arbiter_lock #(.NIN(NIN)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (in_v),
    .last      (in_last),
    .xfer      (xfer),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign in_a = (occ == 2'd2) ? '0 : grant;
  assign xfer = |(in_v & in_a);
  assign pop  = out_v & out_a;

  // Form the outgoing word: payload-only inputs get their table code spliced into the low bits
  always_comb begin
    new_word = in_d[int'(grant_idx)*W +: W];
    if (INSERT_CODE[grant_idx]) new_word[NCODE-1:0] = CODE_TABLE[int'(grant_idx)*NCODE +: NCODE];
    new_entry = '0;
    new_entry.word[W-1:0] = new_word;
    new_entry.src[SW-1:0] = grant_idx;
  end

  // Next occupancy: push and pop together leave it unchanged
  always_comb begin
    occ_n = occ;
    if (xfer && !pop)      occ_n = occ + 2'd1;
    else if (!xfer && pop) occ_n = occ - 2'd1;
  end

  // Skid buffer with the head always in slot 0 so outputs come straight from flops
  always_ff @(posedge clk) begin
    if (reset) begin
      occ       <= '0;
      out_v     <= 1'b0;
      skid_q[0] <= '0;
      skid_q[1] <= '0;
    end else begin
      occ   <= occ_n;
      out_v <= (occ_n != 2'd0);
      if (xfer) begin
        if (occ == 2'd0 || pop) skid_q[0] <= new_entry;
        else                    skid_q[1] <= new_entry;
      end else if (pop) begin
        skid_q[0] <= skid_q[1];
      end
    end
  end

  assign out_d       = skid_q[0].word[W-1:0];
  assign out_src     = skid_q[0].src[SW-1:0];
  assign unused_head = ^skid_q[0];

`ifdef BD_MERGE_COUNT_EN
  // Per-input accepted-word counters; saturate at all-ones, clear beats increment
  always_ff @(posedge clk) begin
    if (reset || cnt_clear) begin
      cnt <= '0;
    end else if (xfer && (cnt[int'(grant_idx)*NCNT +: NCNT] != {NCNT{1'b1}})) begin
      cnt[int'(grant_idx)*NCNT +: NCNT] <= cnt[int'(grant_idx)*NCNT +: NCNT] + NCNT'(1);
    end
  end
`else
  localparam int unused_ncnt = NCNT;
`endif

endmodule
